riscv_apu_slave: RTL and testbench

RISCV_APU_SLAVE -- requirements
Module: riscv_apu_slave

---
 rtl/apu_core_package.sv | 27 ++
 rtl/riscv_apu_result_fifo.sv | 66 ++++++
 rtl/riscv_apu_slave.sv | 128 ++++++++++++
 tb/tb_riscv_apu_slave.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/apu_core_package.sv
// Shared opcode encodings, flag bit positions and FIFO pointer helper for the APU slave.
package apu_core_package;

  typedef enum logic [5:0] {
    APU_OP_ADD = 6'd0,
    APU_OP_SUB = 6'd1,
    APU_OP_MUL = 6'd2,
    APU_OP_MAC = 6'd3,
    APU_OP_MIN = 6'd4,
    APU_OP_MAX = 6'd5
  } apu_op_e;

  localparam int unsigned APU_FLAG_INVALID_BIT = 0;
  localparam int unsigned APU_MAX_DEPTH        = 4;

  // Pointers are sized for the largest legal depth and wrap at the configured one.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr, input int unsigned depth);
    logic [1:0] nxt;
    if (ptr == 2'(depth - 1)) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/riscv_apu_result_fifo.sv
// In-order result buffer between the APU compute pipeline and the core response port.
module riscv_apu_result_fifo
  import apu_core_package::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic          empty_o,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [APU_MAX_DEPTH];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          pop_s;

  assign empty_o   = (count_q == 3'd0);
  assign pop_s     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q, DEPTH);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q, DEPTH);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_i, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < int'(APU_MAX_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/riscv_apu_slave.sv
// Credit-based APU slave: fixed-latency arithmetic pipeline feeding an in-order result FIFO.
module riscv_apu_slave
  import apu_core_package::*;
#(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5,
  parameter int unsigned LAT              = 2,
  parameter int unsigned DEPTH            = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 apu_slave_req_i,
  output logic                                 apu_slave_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]       apu_slave_operands_i,
  input  logic [APU_WOP_CPU-1:0]               apu_slave_op_i,
  input  logic                                 apu_slave_ready_i,
  output logic                                 apu_slave_valid_o,
  output logic [31:0]                          apu_slave_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]          apu_slave_flags_o
);

  localparam int unsigned DW = 32 + APU_NUSFLAGS_CPU;

  logic [2:0]                  outstanding_q, outstanding_d;
  logic                        accept_s, pop_s;
  logic [31:0]                 op_a_s, op_b_s, op_c_s;
  logic [31:0]                 res_s;
  logic [APU_NUSFLAGS_CPU-1:0] flags_s;
  logic                        wr_en_s;
  logic [DW-1:0]               wr_data_s;
  logic [DW-1:0]               head_s;
  logic                        empty_s;

  assign apu_slave_gnt_o = (outstanding_q < 3'(DEPTH));
  assign accept_s        = apu_slave_req_i & apu_slave_gnt_o;
  assign pop_s           = apu_slave_valid_o & apu_slave_ready_i;
  assign op_a_s          = apu_slave_operands_i[0];
  assign op_b_s          = apu_slave_operands_i[1];

  generate
    if (APU_NARGS_CPU > 2) begin : g_op_c
      assign op_c_s = apu_slave_operands_i[2];
    end else begin : g_no_op_c
      assign op_c_s = 32'd0;
    end
  endgenerate

  always_comb begin
    res_s   = 32'd0;
    flags_s = '0;
    case (apu_slave_op_i)
      APU_WOP_CPU'(APU_OP_ADD): res_s = op_a_s + op_b_s;
      APU_WOP_CPU'(APU_OP_SUB): res_s = op_a_s - op_b_s;
      APU_WOP_CPU'(APU_OP_MUL): res_s = op_a_s * op_b_s;
      APU_WOP_CPU'(APU_OP_MAC): res_s = op_a_s * op_b_s + op_c_s;
      APU_WOP_CPU'(APU_OP_MIN): res_s = ($signed(op_a_s) < $signed(op_b_s)) ? op_a_s : op_b_s;
      APU_WOP_CPU'(APU_OP_MAX): res_s = ($signed(op_a_s) > $signed(op_b_s)) ? op_a_s : op_b_s;
      default: flags_s[APU_FLAG_INVALID_BIT] = 1'b1;
    endcase
  end

  // Credits cover both in-flight and buffered results, so the FIFO can never overflow.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept_s, pop_s})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= 3'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // The FIFO write register is the final stage, so LAT-1 registers precede it.
  generate
    if (LAT == 1) begin : g_lat1
      assign wr_en_s   = accept_s;
      assign wr_data_s = {flags_s, res_s};
    end else begin : g_pipe
      logic [LAT-2:0] pv_q;
      logic [DW-1:0]  pd_q [LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          for (int i = 0; i < int'(LAT) - 1; i++) begin
            pd_q[i] <= '0;
          end
        end else begin
          pv_q[0] <= accept_s;
          pd_q[0] <= {flags_s, res_s};
          for (int i = 1; i < int'(LAT) - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            pd_q[i] <= pd_q[i-1];
          end
        end
      end

      assign wr_en_s   = pv_q[LAT-2];
      assign wr_data_s = pd_q[LAT-2];
    end
  endgenerate

  riscv_apu_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_s),
    .wr_data_i (wr_data_s),
    .rd_en_i   (apu_slave_ready_i),
    .empty_o   (empty_s),
    .rd_data_o (head_s)
  );

  assign apu_slave_valid_o  = ~empty_s;
  assign apu_slave_result_o = apu_slave_valid_o ? head_s[31:0] : 32'd0;
  assign apu_slave_flags_o  = apu_slave_valid_o ? head_s[DW-1:32] : '0;

endmodule

// File: tb/tb_riscv_apu_slave.sv
// Directed bench for riscv_apu_slave: vector table of single requests plus multi-cycle sequences.
module tb_riscv_apu_slave;

  logic             clk;
  logic             rst_n;
  logic             req_s;
  logic             gnt_s;
  logic [2:0][31:0] opnd_s;
  logic [5:0]       op_s;
  logic             ready_s;
  logic             valid_s;
  logic [31:0]      result_s;
  logic [4:0]       flags_s;

  int n_vec;
  int n_err;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs [12];

  riscv_apu_slave dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .apu_slave_req_i      (req_s),
    .apu_slave_gnt_o      (gnt_s),
    .apu_slave_operands_i (opnd_s),
    .apu_slave_op_i       (op_s),
    .apu_slave_ready_i    (ready_s),
    .apu_slave_valid_o    (valid_s),
    .apu_slave_result_o   (result_s),
    .apu_slave_flags_o    (flags_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    req_s     = 1'b1;
    op_s      = op;
    opnd_s[0] = a;
    opnd_s[1] = b;
    opnd_s[2] = c;
  endtask

  // One request with ready held high: valid must appear exactly two cycles later for one cycle.
  task automatic run_vec(input string name, input vec_t v);
    @(negedge clk);
    check({name, " gnt"}, 32'(gnt_s), 32'd1);
    drive(v.op, v.a, v.b, v.c);
    @(negedge clk);
    req_s = 1'b0;
    check({name, " valid t+1"}, 32'(valid_s), 32'd0);
    @(negedge clk);
    check({name, " valid t+2"}, 32'(valid_s), 32'd1);
    check({name, " result"}, result_s, v.res);
    check({name, " flags"}, 32'(flags_s), 32'(v.flg));
    @(negedge clk);
    check({name, " valid t+3"}, 32'(valid_s), 32'd0);
    check({name, " result idle"}, result_s, 32'd0);
  endtask

  initial begin
    int accepts;
    logic [31:0] next_a;
    vec_t one_plus_one;

    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req_s   = 1'b0;
    op_s    = 6'd0;
    opnd_s  = '0;
    ready_s = 1'b1;

    vecs[0]  = '{6'd0,  32'd5,          32'd7,          32'd0, 32'd12,         5'd0};
    vecs[1]  = '{6'd1,  32'd2,          32'd5,          32'd0, 32'hFFFFFFFD,   5'd0};
    vecs[2]  = '{6'd2,  32'd3,          32'd4,          32'd0, 32'd12,         5'd0};
    vecs[3]  = '{6'd2,  32'h00010000,   32'h00010000,   32'd0, 32'd0,          5'd0};
    vecs[4]  = '{6'd3,  32'hFFFFFFFF,   32'd2,          32'd3, 32'h00000001,   5'd0};
    vecs[5]  = '{6'd3,  32'd6,          32'd7,          32'd8, 32'd50,         5'd0};
    vecs[6]  = '{6'd4,  32'h80000000,   32'd1,          32'd0, 32'h80000000,   5'd0};
    vecs[7]  = '{6'd4,  32'd7,          32'hFFFFFFFF,   32'd0, 32'hFFFFFFFF,   5'd0};
    vecs[8]  = '{6'd5,  32'h80000000,   32'd1,          32'd0, 32'd1,          5'd0};
    vecs[9]  = '{6'd5,  32'd7,          32'hFFFFFFFF,   32'd0, 32'd7,          5'd0};
    vecs[10] = '{6'h3F, 32'd9,          32'd9,          32'd9, 32'd0,          5'b00001};
    vecs[11] = '{6'd6,  32'd1,          32'd2,          32'd3, 32'd0,          5'b00001};

    // Reset state
    @(negedge clk);
    check("reset gnt", 32'(gnt_s), 32'd1);
    check("reset valid", 32'(valid_s), 32'd0);
    check("reset result", result_s, 32'd0);
    check("reset flags", 32'(flags_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back MUL then SUB
    @(negedge clk);
    drive(6'd2, 32'd3, 32'd4, 32'd0);
    @(negedge clk);
    check("b2b gnt2", 32'(gnt_s), 32'd1);
    drive(6'd1, 32'd2, 32'd5, 32'd0);
    @(negedge clk);
    req_s = 1'b0;
    check("b2b valid1", 32'(valid_s), 32'd1);
    check("b2b result1", result_s, 32'd12);
    @(negedge clk);
    check("b2b valid2", 32'(valid_s), 32'd1);
    check("b2b result2", result_s, 32'hFFFFFFFD);
    @(negedge clk);
    check("b2b drained", 32'(valid_s), 32'd0);

    // Backpressure: continuous requests with ready low
    ready_s = 1'b0;
    accepts = 0;
    next_a  = 32'd1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      drive(6'd0, next_a, 32'd100, 32'd0);
      if (cyc >= 3) begin
        check("bp head stable", result_s, 32'd101);
      end
      if (gnt_s) begin
        accepts++;
        next_a = next_a + 32'd1;
      end
    end
    @(negedge clk);
    req_s = 1'b0;
    check("bp accepts", 32'(accepts), 32'd2);
    check("bp gnt low", 32'(gnt_s), 32'd0);
    check("bp valid", 32'(valid_s), 32'd1);
    ready_s = 1'b1;
    check("bp gnt same cycle as pop", 32'(gnt_s), 32'd0);
    @(negedge clk);
    ready_s = 1'b0;
    check("bp gnt after pop", 32'(gnt_s), 32'd1);
    check("bp second head", result_s, 32'd102);
    @(negedge clk);
    check("bp second held", result_s, 32'd102);
    ready_s = 1'b1;
    @(negedge clk);
    check("bp empty", 32'(valid_s), 32'd0);

    // Reset one cycle after an accept discards the request
    @(negedge clk);
    drive(6'd0, 32'd20, 32'd22, 32'd0);
    @(negedge clk);
    req_s = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst valid", 32'(valid_s), 32'd0);
    check("rst gnt", 32'(gnt_s), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst no stale response", 32'(valid_s), 32'd0);
    end
    one_plus_one = '{6'd0, 32'd1, 32'd1, 32'd0, 32'd2, 5'd0};
    run_vec("post-reset add", one_plus_one);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
